// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the 7-segment scan controller.
//   SEG_W      - segment bus width ({A,B,C,D,E,F,G})
//   SEG_BLANK  - all segments off
//   SEG_TABLE  - hex digit to segment pattern, 1 = lit
//   slot_phase_e - blanking / driving phase within a digit slot
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = '0;

    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef enum logic {
        BLANK_PH,
        DRIVE_PH
    } slot_phase_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load/ready handshake carrying a display value.
//   load   - request to capture value/dp_in/lz_en (master -> slave)
//   ready  - shadow register free (slave -> master)
//   value  - packed hex nibbles, digit 0 in bits [3:0]
//   dp_in  - decimal point per digit, 1 = lit
//   lz_en  - leading-zero suppression enable
interface seg_scan_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic                    ready;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     dp_in;
    logic                    lz_en;

    modport master (output load, value, dp_in, lz_en, input ready);
    modport slave  (input load, value, dp_in, lz_en, output ready);
endinterface

// File: rtl/seg_hex_dec.sv
// seg_hex_dec: combinational hex nibble to 7-segment decoder.
//   nibble - hex digit in
//   seg    - {A,B,C,D,E,F,G}, 1 = lit
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an N-digit 7-segment bank.
//   clk, rst_n  - clock, asynchronous active-low reset
//   bus         - load/ready handshake delivering {value, dp_in, lz_en}
//   seg         - shared segment bus {A..G}, 1 = lit
//   dp          - decimal point of the active digit
//   an          - one-hot digit enable
//   frame_done  - one-cycle pulse as the last digit slot ends
// New values wait in a shadow register and are committed only at a frame
// boundary, so a frame is never drawn from two different values.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_ctrl_if.slave    bus,
    output logic [SEG_W-1:0]  seg,
    output logic              dp,
    output logic [N_DIGITS-1:0] an,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    pending_q;
    logic [4*N_DIGITS-1:0]   shadow_value_q, disp_value_q;
    logic [N_DIGITS-1:0]     shadow_dp_q, disp_dp_q;
    logic                    shadow_lz_q, disp_lz_q;

    logic                    slot_end, frame_end, accept;
    slot_phase_e             phase;
    logic [3:0]              nibble;
    logic [SEG_W-1:0]        dec_seg;
    logic [N_DIGITS-1:0]     lz_mask;
    logic                    zero_run;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);
    assign accept    = bus.load && bus.ready;
    assign bus.ready = ~pending_q;

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (slot_end) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Shadow capture and frame-boundary commit. accept needs pending_q=0 and
    // commit needs pending_q=1, so both can never fire in the same cycle; a
    // load taken on the boundary cycle therefore waits for the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q      <= 1'b0;
            shadow_value_q <= '0;
            shadow_dp_q    <= '0;
            shadow_lz_q    <= 1'b0;
            disp_value_q   <= '0;
            disp_dp_q      <= '0;
            disp_lz_q      <= 1'b0;
        end else if (accept) begin
            pending_q      <= 1'b1;
            shadow_value_q <= bus.value;
            shadow_dp_q    <= bus.dp_in;
            shadow_lz_q    <= bus.lz_en;
        end else if (frame_end && pending_q) begin
            pending_q    <= 1'b0;
            disp_value_q <= shadow_value_q;
            disp_dp_q    <= shadow_dp_q;
            disp_lz_q    <= shadow_lz_q;
        end
    end

    // Digit i is suppressed when it and every digit above it are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (disp_value_q[4*i +: 4] == 4'h0);
            lz_mask[i] = disp_lz_q && zero_run && (i != 0);
        end
    end

    assign phase  = (cnt_q < BLANK_CNT) ? BLANK_PH : DRIVE_PH;
    assign nibble = disp_value_q[{idx_q, 2'b00} +: 4];

    seg_hex_dec u_hex_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // One register stage for all pin outputs keeps an and seg in lockstep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_BLANK;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (phase == DRIVE_PH) begin
                an  <= N_DIGITS'(1) << idx_q;
                seg <= lz_mask[idx_q] ? SEG_BLANK : dec_seg;
                dp  <= disp_dp_q[idx_q];
            end else begin
                an  <= '0;
                seg <= SEG_BLANK;
                dp  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int P     = 4;
    localparam int B     = 1;
    localparam int FRAME = N * P;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    seg_scan_ctrl_if #(.N_DIGITS(N)) bus ();

    seg_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P), .BLANK(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    // Reference model: position within the frame as a plain cycle count.
    function automatic logic [3:0] f_an(input int pos);
        if (pos % P < B) return 4'b0;
        return 4'(1 << (pos / P));
    endfunction

    function automatic logic [6:0] f_seg(input int pos, input logic [15:0] v, input bit lz);
        int d;
        d = pos / P;
        if (pos % P < B) return 7'h00;
        if (lz && d != 0 && (v >> (4 * d)) == 16'h0) return 7'h00;
        return hex7(4'(v >> (4 * d)));
    endfunction

    function automatic bit f_dp(input int pos, input logic [3:0] dpv);
        if (pos % P < B) return 1'b0;
        return dpv[pos / P];
    endfunction

    int         m_pos;
    bit         m_pending;
    logic [15:0] m_sh_val, m_val;
    logic [3:0] m_sh_dp, m_dp;
    bit         m_sh_lz, m_lz;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    bit         e_dp, e_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos <= 0; m_pending <= 1'b0;
            m_sh_val <= '0; m_sh_dp <= '0; m_sh_lz <= 1'b0;
            m_val <= '0; m_dp <= '0; m_lz <= 1'b0;
            e_an <= '0; e_seg <= '0; e_dp <= 1'b0; e_fd <= 1'b0;
        end else begin
            e_an  <= f_an(m_pos);
            e_seg <= f_seg(m_pos, m_val, m_lz);
            e_dp  <= f_dp(m_pos, m_dp);
            e_fd  <= (m_pos == FRAME - 1);
            if (bus.load && !m_pending) begin
                m_pending <= 1'b1;
                m_sh_val <= bus.value; m_sh_dp <= bus.dp_in; m_sh_lz <= bus.lz_en;
            end else if (m_pos == FRAME - 1 && m_pending) begin
                m_pending <= 1'b0;
                m_val <= m_sh_val; m_dp <= m_sh_dp; m_lz <= m_sh_lz;
            end
            m_pos <= (m_pos + 1) % FRAME;
        end
    end

    // Continuous comparison against the model on the inactive edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("an", an, e_an);
            check("seg", seg, e_seg);
            check("dp", dp, e_dp);
            check("frame_done", frame_done, e_fd);
            check("ready", bus.ready, !m_pending);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input bit lz);
        for (int k = 0; k < 4 * FRAME && bus.ready !== 1'b1; k++) step();
        check("load_wait_ready", bus.ready, 1'b1);
        bus.load = 1'b1; bus.value = v; bus.dp_in = d; bus.lz_en = lz;
        step();
        bus.load = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        for (int k = 0; k < 3 * FRAME && bus.ready !== 1'b1; k++) step();
        check(name, bus.ready, 1'b1);
    endtask

    // Observe one full frame right after a commit and compare per digit.
    task automatic capture_frame(input string tag, input logic [27:0] exp_segs,
                                 input logic [3:0] exp_dp);
        logic [6:0] got [4];
        logic [3:0] gdp;
        int         hits [4];
        for (int j = 0; j < 4; j++) begin got[j] = 7'h55; hits[j] = 0; end
        gdp = 4'bxxxx;
        for (int c = 0; c < FRAME; c++) begin
            step();
            for (int j = 0; j < 4; j++) begin
                if (an[j] === 1'b1) begin
                    got[j] = seg; gdp[j] = dp; hits[j]++;
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("%s_d%0d_seg", tag, j), got[j], exp_segs[7*j +: 7]);
            check($sformatf("%s_d%0d_slots", tag, j), hits[j], P - B);
        end
        check($sformatf("%s_dp", tag), gdp, exp_dp);
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        bit          lz;
        logic [27:0] segs;   // {d3, d2, d1, d0}
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        tbl[0] = '{16'h12AF, 4'b0100, 1'b0, {7'h30, 7'h6D, 7'h77, 7'h47}};
        tbl[1] = '{16'h0070, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h70, 7'h7E}};
        tbl[2] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}};
        tbl[3] = '{16'h0305, 4'b1010, 1'b1, {7'h00, 7'h79, 7'h7E, 7'h5B}};
        tbl[4] = '{16'h89BD, 4'b0000, 1'b0, {7'h7F, 7'h7B, 7'h1F, 7'h3D}};
        tbl[5] = '{16'hCE46, 4'b0001, 1'b0, {7'h4E, 7'h4F, 7'h33, 7'h5F}};
        tbl[6] = '{16'h0000, 4'b1111, 1'b0, {7'h7E, 7'h7E, 7'h7E, 7'h7E}};
        tbl[7] = '{16'h3000, 4'b0000, 1'b1, {7'h79, 7'h7E, 7'h7E, 7'h7E}};

        bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.lz_en = 1'b0;

        // Reset values, then first driven digit two cycles after release.
        repeat (3) step();
        check("rst_an", an, 4'b0);
        check("rst_seg", seg, 7'h00);
        check("rst_dp", dp, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_ready", bus.ready, 1'b1);
        rst_n = 1'b1;
        step();
        check("rel_blank_an", an, 4'b0000);
        step();
        check("rel_first_an", an, 4'b0001);
        check("rel_first_seg", seg, 7'h7E);

        // Table of display values.
        for (int r = 0; r < 8; r++) begin
            do_load(tbl[r].value, tbl[r].dp, tbl[r].lz);
            check($sformatf("row%0d_ready_fall", r), bus.ready, 1'b0);
            wait_ready($sformatf("row%0d_commit", r));
            capture_frame($sformatf("row%0d", r), tbl[r].segs, tbl[r].dp);
        end

        // Second load while busy is ignored.
        do_load(16'h1111, 4'b0000, 1'b0);
        bus.load = 1'b1; bus.value = 16'h2222; bus.dp_in = 4'hF; bus.lz_en = 1'b1;
        step();
        bus.load = 1'b0;
        check("b2b_still_busy", bus.ready, 1'b0);
        wait_ready("b2b_commit");
        capture_frame("b2b", {7'h30, 7'h30, 7'h30, 7'h30}, 4'b0000);

        // Load taken on the boundary cycle waits a whole extra frame.
        for (k = 0; k < 2 * FRAME && !(m_pos == FRAME - 1 && bus.ready === 1'b1); k++) step();
        check("bnd_align", m_pos, FRAME - 1);
        bus.load = 1'b1; bus.value = 16'h0F0F; bus.dp_in = 4'b0000; bus.lz_en = 1'b0;
        step();
        bus.load = 1'b0;
        k = 0;
        while (bus.ready !== 1'b1 && k < 3 * FRAME) begin step(); k++; end
        check("bnd_commit_latency", k, FRAME);
        capture_frame("bnd", {7'h7E, 7'h47, 7'h7E, 7'h47}, 4'b0000);

        // Randomized traffic, including loads while busy.
        for (int c = 0; c < 400; c++) begin
            bus.load  = ($urandom % 3 == 0);
            bus.value = 16'(16'($urandom) >> ($urandom % 17));
            bus.dp_in = 4'($urandom);
            bus.lz_en = 1'($urandom);
            step();
        end
        bus.load = 1'b0;
        wait_ready("rand_drain");

        // Asynchronous reset while a value is pending, mid-slot.
        for (k = 0; k < 2 * FRAME && m_pos != 5; k++) step();
        do_load(16'h8888, 4'hF, 1'b0);
        step(); step();
        check("mid_pending", bus.ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an", an, 4'b0);
        check("async_seg", seg, 7'h00);
        check("async_dp", dp, 1'b0);
        check("async_frame_done", frame_done, 1'b0);
        check("async_ready", bus.ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("restart_blank_an", an, 4'b0000);
        step();
        check("restart_an", an, 4'b0001);
        check("restart_seg", seg, 7'h7E);
        check("restart_dp", dp, 1'b0);
        repeat (2 * FRAME + 3) step();
        check("restart_ready", bus.ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode/common-cathode 7-segment display bank. Accepts a packed hex value through a load/ready handshake and shadows it until a frame boundary so the display never tears. Cycles one digit enable at a time at a programmable rate, with inter-digit blanking. Drives the shared segment bus through a hex-to-segment decoder, with optional leading-zero suppression. Sits between the register/CPU side and the board's segment and anode pins.

## Interface
- N_DIGITS, 4: number of multiplexed digits (2..8)
- PRESCALE, 50000: clock cycles per digit slot (≥ 2)
- BLANK, 500: cycles at the start of each slot with all digit enables off (0 ≤ BLANK < PRESCALE)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  request to capture value/dp_in/lz_en; accepted only when ready=1
- ready  out  1  high when the shadow register is free
- value  in  4*N_DIGITS  packed hex nibbles; digit 0 = value[3:0] (rightmost)
- dp_in  in  N_DIGITS  decimal point per digit, 1 = lit
- lz_en  in  1  leading-zero suppression enable, captured with load
- seg  out  7  {A,B,C,D,E,F,G}, 1 = lit
- dp  out  1  decimal point of the active digit, 1 = lit
- an  out  N_DIGITS  one-hot digit enable, 1 = active
- frame_done  out  1  one-cycle pulse when the last digit slot ends

## Operation
- Registers: shadow {value, dp, lz} with a pending flag; display {value, dp, lz}; prescaler cnt (0..PRESCALE-1); digit index idx (0..N_DIGITS-1).
- Handshake: load && ready → shadow captured, pending=1, ready=0 next cycle. load while ready=0 is ignored (no capture, no error).
- Commit: on the frame-boundary cycle (cnt=PRESCALE-1 and idx=N_DIGITS-1), if pending was already 1 before that cycle, then shadow → display, pending=0, and ready=1 next cycle. A load accepted on the boundary cycle itself is committed at the following boundary.
- Scan: cnt increments every cycle. At PRESCALE-1, cnt wraps to 0 and idx advances. idx wraps from N_DIGITS-1 to 0, and frame_done pulses on that wrap.
- States per slot: BLANK_PH while cnt < BLANK, with an=0, seg=0, dp=0. DRIVE_PH otherwise, with an=one-hot(idx), seg=decode(nibble[idx]), dp=dp[idx].
- Leading-zero suppression (lz=1): digit i is blanked (seg=0, dp follows dp[i]) if all nibbles from i through N_DIGITS-1 are zero. Digit 0 is never suppressed. an still asserts for a suppressed digit.
- Decode map, standard hex (seg hex):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47

## Timing
- All outputs are registered. seg, an and dp lag the cnt/idx state by 1 cycle and change together, so there is no glitch between an and seg.
- Reset values: an=0, seg=0, dp=0, frame_done=0, ready=1, pending=0, display=0, lz=0, cnt=0, idx=0.
- Per digit slot: PRESCALE cycles, of which PRESCALE-BLANK cycles are driven. Frame = N_DIGITS*PRESCALE cycles.
- Handshake latency:
  - ready falls 1 cycle after an accepted load.
  - A value is visible at most 2 frames + 1 cycle after it is accepted.
  - ready rises 1 cycle after commit.
- Reset mid-frame: everything returns to reset values immediately (asynchronously). Scanning restarts at idx=0, cnt=0 after rst_n deasserts. A pending shadow is discarded.

## Structure
- Package seg_pkg:
  - SEG_W=7
  - 16-entry hex segment constant table
  - SEG_BLANK='0
  - slot-phase enum {BLANK_PH, DRIVE_PH}
- Sub-module seg_hex_dec: purely combinational nibble→seg[6:0] decoder using the package table. It is instantiated once on the muxed nibble.
- Top level: handshake/shadow, prescaler, scan counter, leading-zero mask, output registers.

## Test plan
All scenarios use N_DIGITS=4, PRESCALE=4, BLANK=1.
- Reset: hold rst_n=0, then release. Required: an=0000, seg=00, ready=1. First driven an=0001 appears 2 cycles after release (1 blank cycle, then 1 register stage). seg=7E.
- Load 0x12AF, lz=0, dp_in=0100. Required: after commit, one frame shows an=0001/seg=47, 0010/seg=77, 0100/seg=6D with dp=1, 1000/seg=30. Each digit is driven 3 of 4 cycles. frame_done pulses every 16 cycles.
- Load 0x0070, lz=1. Required: digits 3 and 2 show seg=00 with an still asserted. Digit 1 shows 70, digit 0 shows 7E. Load 0x0000, lz=1: only digit 0 shows 7E.
- Back-to-back: load 0x1111, then pulse load with 0x2222 while ready=0. Required: second load is ignored, 0x1111 is committed, ready returns to 1. A load on the exact boundary cycle is committed one frame later.
- Assert rst_n=0 while pending=1 in mid-slot. Required: outputs clear asynchronously, ready=1, display=0 (seg=7E on digit 0 after restart).
